// File: rtl/branch_unit.sv
// Program counter and branch resolution: NOP/JMP/Jcc/CALL/RET with a LIFO return stack.
// Latency: one cycle; the op presented with en=1 shows on pc/taken/stack_cnt after the next edge.
// Backpressure: none; en=0 stalls the unit (pc and stack hold, taken drops to 0).
//
// Ports: clk/rst (async active-high), en, op[2:0], signed_cmp, cmp_a, cmp_b, offset,
//        err_clr -> pc, taken, stack_cnt, stack_err (all registered).
module branch_unit #(
    parameter int               WIDTH    = 16,
    parameter int               DEPTH    = 4,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic [2:0]                 op,
    input  logic                       signed_cmp,
    input  logic [WIDTH-1:0]           cmp_a,
    input  logic [WIDTH-1:0]           cmp_b,
    input  logic [WIDTH-1:0]           offset,
    input  logic                       err_clr,
    output logic [WIDTH-1:0]           pc,
    output logic                       taken,
    output logic [$clog2(DEPTH+1)-1:0] stack_cnt,
    output logic                       stack_err
);

    localparam int CW    = $clog2(DEPTH + 1);
    // Array is sized to the full counter range so stack_cnt indexes it directly;
    // entries at or above DEPTH are never written.
    localparam int SLOTS = 1 << CW;

    localparam logic [2:0] OP_NOP  = 3'd0;
    localparam logic [2:0] OP_JMP  = 3'd1;
    localparam logic [2:0] OP_JLT  = 3'd2;
    localparam logic [2:0] OP_JGT  = 3'd3;
    localparam logic [2:0] OP_JEQ  = 3'd4;
    localparam logic [2:0] OP_JNE  = 3'd5;
    localparam logic [2:0] OP_CALL = 3'd6;
    localparam logic [2:0] OP_RET  = 3'd7;

    logic [WIDTH-1:0] stack [0:SLOTS-1];

    logic [WIDTH-1:0] seq;
    logic [WIDTH-1:0] tgt;
    logic [WIDTH-1:0] pc_nxt;
    logic [CW-1:0]    top_idx;
    logic             taken_nxt;
    logic             push;
    logic             pop;
    logic             err_set;
    logic             lt;
    logic             gt;
    logic             full;
    logic             empty;

    always_comb begin
        // Both wrap modulo 2^WIDTH by construction.
        seq     = pc + WIDTH'(1);
        tgt     = pc + offset;
        top_idx = stack_cnt - CW'(1);
        full    = (stack_cnt == CW'(DEPTH));
        empty   = (stack_cnt == '0);

        if (signed_cmp) begin
            lt = $signed(cmp_a) < $signed(cmp_b);
            gt = $signed(cmp_a) > $signed(cmp_b);
        end else begin
            lt = cmp_a < cmp_b;
            gt = cmp_a > cmp_b;
        end

        pc_nxt    = seq;
        taken_nxt = 1'b0;
        push      = 1'b0;
        pop       = 1'b0;
        err_set   = 1'b0;

        case (op)
            OP_NOP: ;
            OP_JMP: begin
                pc_nxt    = tgt;
                taken_nxt = 1'b1;
            end
            OP_JLT, OP_JGT, OP_JEQ, OP_JNE: begin
                logic cond;
                case (op)
                    OP_JLT:  cond = lt;
                    OP_JGT:  cond = gt;
                    OP_JEQ:  cond = (cmp_a == cmp_b);
                    default: cond = (cmp_a != cmp_b);
                endcase
                if (cond) begin
                    pc_nxt    = tgt;
                    taken_nxt = 1'b1;
                end
            end
            OP_CALL: begin
                if (full) begin
                    err_set = en;
                end else begin
                    push      = en;
                    pc_nxt    = tgt;
                    taken_nxt = 1'b1;
                end
            end
            OP_RET: begin
                if (empty) begin
                    err_set = en;
                end else begin
                    pop       = en;
                    pc_nxt    = stack[top_idx];
                    taken_nxt = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc        <= RESET_PC;
            taken     <= 1'b0;
            stack_cnt <= '0;
            stack_err <= 1'b0;
        end else begin
            if (en) begin
                pc    <= pc_nxt;
                taken <= taken_nxt;
                if (push) begin
                    stack_cnt <= stack_cnt + CW'(1);
                end else if (pop) begin
                    stack_cnt <= stack_cnt - CW'(1);
                end
            end else begin
                taken <= 1'b0;
            end
            // A new error on the same edge as a clear must leave the flag set.
            if (err_set) begin
                stack_err <= 1'b1;
            end else if (err_clr) begin
                stack_err <= 1'b0;
            end
        end
    end

    // Stack contents need no reset; occupancy alone defines what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            stack[stack_cnt] <= seq;
        end
    end

endmodule

// File: tb/tb_branch_unit.sv
module tb_branch_unit;

    localparam int W = 16;
    localparam int D = 4;

    typedef struct packed {
        logic [W-1:0] pc;
        logic         taken;
        logic [2:0]   cnt;
        logic         err;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         en = 1'b0;
    logic [2:0]   op = 3'd0;
    logic         signed_cmp = 1'b0;
    logic [W-1:0] cmp_a = '0;
    logic [W-1:0] cmp_b = '0;
    logic [W-1:0] offset = '0;
    logic         err_clr = 1'b0;
    logic [W-1:0] pc;
    logic         taken;
    logic [2:0]   stack_cnt;
    logic         stack_err;

    int checks = 0;
    int failures = 0;

    exp_t         sb_q[$];

    // Reference model state
    logic [W-1:0] m_pc;
    logic [W-1:0] m_stack[$];
    logic         m_err;

    branch_unit #(.WIDTH(W), .DEPTH(D), .RESET_PC(16'h0000)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .op         (op),
        .signed_cmp (signed_cmp),
        .cmp_a      (cmp_a),
        .cmp_b      (cmp_b),
        .offset     (offset),
        .err_clr    (err_clr),
        .pc         (pc),
        .taken      (taken),
        .stack_cnt  (stack_cnt),
        .stack_err  (stack_err)
    );

    always #5 clk = ~clk;

    // Monitor: every clock edge (and the asynchronous reset edge) produces an
    // observable state; compare it against the oldest outstanding expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk or posedge rst);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                checks++;
                if (pc !== e.pc || taken !== e.taken || stack_cnt !== e.cnt || stack_err !== e.err) begin
                    failures++;
                    $display("FAIL state t=%0t: got pc=%h taken=%b cnt=%0d err=%b, want pc=%h taken=%b cnt=%0d err=%b",
                             $time, pc, taken, stack_cnt, stack_err, e.pc, e.taken, e.cnt, e.err);
                end
            end
        end
    end

    function automatic exp_t model_state(input logic tk);
        exp_t e;
        e.pc    = m_pc;
        e.taken = tk;
        e.cnt   = 3'(m_stack.size());
        e.err   = m_err;
        return e;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        en      = 1'b0;
        err_clr = 1'b0;
        m_pc    = '0;
        m_stack.delete();
        m_err   = 1'b0;
        sb_q.push_back(model_state(1'b0));   // seen right after the async edge
        sb_q.push_back(model_state(1'b0));   // still held through the next clock
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic step(input logic e, input logic [2:0] o, input logic sc,
                        input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] off, input logic clr);
        logic [W-1:0] seq;
        logic [W-1:0] tgt;
        logic         tk;
        logic         cond;
        logic         new_err;
        @(negedge clk);
        en = e; op = o; signed_cmp = sc; cmp_a = a; cmp_b = b; offset = off; err_clr = clr;
        seq = m_pc + 16'd1;
        tgt = m_pc + off;
        tk = 1'b0;
        new_err = 1'b0;
        if (e) begin
            case (o)
                3'd0: m_pc = seq;
                3'd1: begin m_pc = tgt; tk = 1'b1; end
                3'd2, 3'd3, 3'd4, 3'd5: begin
                    case (o)
                        3'd2: cond = sc ? (int'($signed(a)) < int'($signed(b))) : (int'(a) < int'(b));
                        3'd3: cond = sc ? (int'($signed(a)) > int'($signed(b))) : (int'(a) > int'(b));
                        3'd4: cond = (a == b);
                        default: cond = (a != b);
                    endcase
                    tk = cond;
                    m_pc = cond ? tgt : seq;
                end
                3'd6: begin
                    if (m_stack.size() < D) begin
                        m_stack.push_back(seq);
                        m_pc = tgt;
                        tk = 1'b1;
                    end else begin
                        m_pc = seq;
                        new_err = 1'b1;
                    end
                end
                default: begin
                    if (m_stack.size() > 0) begin
                        m_pc = m_stack.pop_back();
                        tk = 1'b1;
                    end else begin
                        m_pc = seq;
                        new_err = 1'b1;
                    end
                end
            endcase
        end
        if (clr) m_err = 1'b0;
        if (new_err) m_err = 1'b1;
        sb_q.push_back(model_state(tk));
    endtask

    task automatic set_pc(input logic [W-1:0] v);
        step(1'b1, 3'd1, 1'b0, '0, '0, v - m_pc, 1'b0);
    endtask

    initial begin
        m_pc = '0;
        m_err = 1'b0;
        repeat (2) @(negedge clk);

        // 1: sequential flow and reset mid-run
        do_reset();
        repeat (3) step(1'b1, 3'd0, 1'b0, '0, '0, '0, 1'b0);
        do_reset();

        // 2: signed vs unsigned JLT
        set_pc(16'h0010);
        step(1'b1, 3'd2, 1'b1, 16'hFFFF, 16'h0001, 16'h0020, 1'b0);
        set_pc(16'h0010);
        step(1'b1, 3'd2, 1'b0, 16'hFFFF, 16'h0001, 16'h0020, 1'b0);

        // 3: negative offset and pc wrap
        set_pc(16'h0005);
        step(1'b1, 3'd1, 1'b0, '0, '0, 16'hFFFA, 1'b0);
        step(1'b1, 3'd0, 1'b0, '0, '0, '0, 1'b0);

        // 4: call / return
        set_pc(16'h0100);
        step(1'b1, 3'd6, 1'b0, '0, '0, 16'h0100, 1'b0);
        step(1'b1, 3'd7, 1'b0, '0, '0, '0, 1'b0);

        // 5: overflow, LIFO unwinding, underflow
        for (int i = 0; i < 5; i++) step(1'b1, 3'd6, 1'b0, '0, '0, 16'(16'h0040 * (i + 1)), 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, 3'd7, 1'b0, '0, '0, '0, 1'b0);

        // 6: err_clr while stalled, error beats clear, EQ/NE
        step(1'b0, 3'd6, 1'b0, '0, '0, 16'h0100, 1'b1);
        step(1'b1, 3'd7, 1'b0, '0, '0, '0, 1'b1);
        step(1'b1, 3'd4, 1'b0, 16'h1234, 16'h1234, 16'h0010, 1'b0);
        step(1'b1, 3'd5, 1'b0, 16'h1234, 16'h1234, 16'h0010, 1'b0);
        step(1'b0, 3'd1, 1'b0, '0, '0, 16'h0100, 1'b0);

        // Random traffic
        for (int i = 0; i < 800; i++) begin
            logic [W-1:0] a;
            logic [W-1:0] b;
            a = 16'($urandom);
            b = ($urandom_range(0, 3) == 0) ? a : 16'($urandom);
            if ($urandom_range(0, 299) == 0) do_reset();
            step($urandom_range(0, 9) < 8, 3'($urandom_range(0, 7)), 1'($urandom),
                 a, b, 16'($urandom), $urandom_range(0, 19) == 0);
        end

        @(negedge clk);
        en = 1'b0;
        err_clr = 1'b0;
        for (int i = 0; i < 20 && sb_q.size() > 0; i++) @(negedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d expectations left, want 0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
